// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the sram-like request arbiter: master ID encodings,
// default outstanding depth and the ring-pointer helper used by the ID FIFO.
package sram_req_arbiter_pkg;

  // Master identifiers carried through the in-order ID FIFO
  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  // Default number of accepted requests that may await data_ok
  localparam int OUTSTANDING_DEFAULT = 2;

  // Physical storage of the ID FIFO; logical depth is 1..FIFO_MAX_DEPTH
  localparam int FIFO_MAX_DEPTH = 4;

  // Advance a ring pointer, wrapping at the logical depth
  function automatic logic [1:0] ptr_next(input logic [1:0] ptr, input int depth);
    logic [1:0] nxt;
    if (int'(ptr) >= depth - 1) begin
      nxt = 2'd0;
    end else begin
      nxt = ptr + 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sram_req_arbiter_id_fifo.sv
// In-order FIFO of 1-bit master IDs. Tracks which master owns each
// accepted-but-unanswered memory request. full is a registered flag so
// that the request path never sees a combinational path from the pop side.
module id_fifo
  import sram_req_arbiter_pkg::*;
#(
  parameter int DEPTH = OUTSTANDING_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_push,
  input  logic i_pop,
  input  logic i_id,
  output logic o_full,
  output logic o_empty,
  output logic o_head
);

  logic [FIFO_MAX_DEPTH-1:0] r_mem;
  logic [1:0]                r_wr_ptr;
  logic [1:0]                r_rd_ptr;
  logic [2:0]                r_count;
  logic                      r_full;
  logic                      w_push;
  logic                      w_pop;
  logic [2:0]                w_count_nxt;

  // Pushes into a full FIFO and pops from an empty one are dropped
  assign w_push = i_push & ~r_full;
  assign w_pop  = i_pop & (r_count != 3'd0);

  // Next occupancy; simultaneous push and pop leaves it unchanged
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 3'd1;
      2'b01:   w_count_nxt = r_count - 3'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage, pointers, occupancy and the registered full flag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_mem    <= '0;
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_id;
        r_wr_ptr        <= ptr_next(r_wr_ptr, DEPTH);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr, DEPTH);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == 3'(DEPTH));
    end
  end

  assign o_full  = r_full;
  assign o_empty = (r_count == 3'd0);
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/sram_req_arbiter.sv
// Two-master (inst/data) to one-slave arbiter for the sram-like protocol.
// Fixed priority data > inst, grant locked while the slave stalls an
// asserted request, and responses routed back in acceptance order through
// an ID FIFO bounded by OUTSTANDING.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = OUTSTANDING_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction master
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data master
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // memory slave
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  logic r_lock;
  logic r_lock_id;
  logic w_lock_hit;
  logic w_grant_id;
  logic w_mem_req;
  logic w_accept;
  logic w_pop;
  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_fifo_head;

  // A lock only counts while its owner still holds req, so a master that
  // withdraws cannot leave the other one sourcing the wrong fields
  assign w_lock_hit = r_lock & ((r_lock_id == ID_DATA) ? data_req : inst_req);

  // Grant selection: locked owner first, then data over inst; idle selects data
  always_comb begin
    w_grant_id = ID_DATA;
    if (w_lock_hit) begin
      w_grant_id = r_lock_id;
    end else if (data_req) begin
      w_grant_id = ID_DATA;
    end else if (inst_req) begin
      w_grant_id = ID_INST;
    end else begin
      w_grant_id = ID_DATA;
    end
  end

  // Request is gated only by registered state and reset, never by mem_data_ok
  assign w_mem_req = (inst_req | data_req) & ~w_fifo_full & resetn;
  assign w_accept  = w_mem_req & mem_addr_ok;
  assign w_pop     = mem_data_ok & ~w_fifo_empty & resetn;

  // Request-field mux toward the memory slave
  always_comb begin
    if (w_grant_id == ID_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else begin
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_wstrb = inst_wstrb;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end
  end

  // Hold the grant while a request is stalled; free it on acceptance or idle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_lock    <= 1'b0;
      r_lock_id <= ID_DATA;
    end else if (w_mem_req && !mem_addr_ok) begin
      r_lock    <= 1'b1;
      r_lock_id <= w_grant_id;
    end else begin
      r_lock    <= 1'b0;
      r_lock_id <= r_lock_id;
    end
  end

  id_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_id    (w_grant_id),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_head  (w_fifo_head)
  );

  assign mem_req      = w_mem_req;
  assign inst_addr_ok = w_accept & (w_grant_id == ID_INST);
  assign data_addr_ok = w_accept & (w_grant_id == ID_DATA);
  assign inst_data_ok = w_pop & (w_fifo_head == ID_INST);
  assign data_data_ok = w_pop & (w_fifo_head == ID_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Scoreboard bench for sram_req_arbiter: a directed cycle table followed by
// a randomised traffic phase with a latency-varying memory model.
module tb_sram_req_arbiter;

  localparam logic [31:0] IADDR = 32'h1000_0010;
  localparam logic [31:0] DADDR = 32'h2000_0020;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  sram_req_arbiter #(.OUTSTANDING(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic        rstn, ireq, dreq, aok, dok;
    logic [31:0] rdata;
    logic        mreq, iaok, daok, gdata, idok, ddok;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } mem_t;

  vec_t        exp_q[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  mem_t        mem_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_iss_i = 0, n_iss_d = 0, n_rcv_i = 0, n_rcv_d = 0;
  logic        rand_mode = 1'b0;

  function automatic vec_t mk(input logic rstn, ireq, dreq, aok, dok, input logic [31:0] rdata,
                              input logic mreq, iaok, daok, gdata, idok, ddok);
    vec_t v;
    v.idx = 0; v.rstn = rstn; v.ireq = ireq; v.dreq = dreq; v.aok = aok; v.dok = dok;
    v.rdata = rdata; v.mreq = mreq; v.iaok = iaok; v.daok = daok; v.gdata = gdata;
    v.idok = idok; v.ddok = ddok;
    return v;
  endfunction

  // Monitor: compares DUT outputs against queued expectations
  initial begin
    vec_t        e;
    logic [4:0]  obs, req;
    logic [31:0] x;
    forever begin
      @(negedge clk);
      if (!rand_mode) begin
        if (exp_q.size() != 0) begin
          e   = exp_q.pop_front();
          obs = {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};
          req = {e.mreq, e.iaok, e.daok, e.idok, e.ddok};
          n_cmp++;
          if (obs !== req) begin
            n_err++;
            $display("FAIL vec%0d_hs: {mreq,iaok,daok,idok,ddok} got %b expected %b", e.idx, obs, req);
          end
          if (e.mreq) begin
            n_cmp++;
            if (mem_addr !== (e.gdata ? DADDR : IADDR) || mem_wr !== e.gdata) begin
              n_err++;
              $display("FAIL vec%0d_mux: mem_addr=%h mem_wr=%b expected %h/%b", e.idx, mem_addr,
                       mem_wr, (e.gdata ? DADDR : IADDR), e.gdata);
            end
          end
          if (e.idok || e.ddok) begin
            n_cmp++;
            if (inst_rdata !== e.rdata || data_rdata !== e.rdata) begin
              n_err++;
              $display("FAIL vec%0d_rdata: inst=%h data=%h expected %h", e.idx, inst_rdata,
                       data_rdata, e.rdata);
            end
          end
        end
      end else begin
        if (inst_data_ok) begin
          n_cmp++;
          if (exp_i.size() == 0) begin
            n_err++;
            $display("FAIL rand_inst_resp: unexpected inst_data_ok rdata=%h expected none", inst_rdata);
          end else begin
            x = exp_i.pop_front();
            n_rcv_i++;
            if (inst_rdata !== x) begin
              n_err++;
              $display("FAIL rand_inst_resp: rdata=%h expected %h", inst_rdata, x);
            end
          end
        end
        if (data_data_ok) begin
          n_cmp++;
          if (exp_d.size() == 0) begin
            n_err++;
            $display("FAIL rand_data_resp: unexpected data_data_ok rdata=%h expected none", data_rdata);
          end else begin
            x = exp_d.pop_front();
            n_rcv_d++;
            if (data_rdata !== x) begin
              n_err++;
              $display("FAIL rand_data_resp: rdata=%h expected %h", data_rdata, x);
            end
          end
        end
      end
    end
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus: directed table, then random traffic with a memory model
  initial begin
    vec_t        tbl[$];
    vec_t        v;
    mem_t        m;
    int          cyc;
    logic        i_pend, d_pend;
    logic [31:0] i_cur, d_cur;
    int          i_seq, d_seq;

    resetn = 1'b0; inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    mem_rdata = 32'h0;
    inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hF; inst_addr = IADDR; inst_wdata = 32'h1111_1111;
    data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hF; data_addr = DADDR; data_wdata = 32'h2222_2222;

    //           rstn ireq dreq aok dok rdata         mreq iaok daok gdat idok ddok
    tbl.push_back(mk(0, 1, 1, 1, 1, 32'hDEAD_0000, 0, 0, 0, 1, 0, 0)); // reset holds all low
    tbl.push_back(mk(0, 1, 1, 1, 1, 32'hDEAD_0000, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 32'h0,         1, 0, 1, 1, 0, 0)); // data wins, first cycle
    tbl.push_back(mk(1, 1, 0, 1, 0, 32'h0,         1, 1, 0, 0, 0, 0)); // inst next cycle
    tbl.push_back(mk(1, 1, 1, 1, 0, 32'h0,         0, 0, 0, 1, 0, 0)); // full
    tbl.push_back(mk(1, 0, 0, 0, 1, 32'hA5A5_0001, 0, 0, 0, 1, 0, 1)); // data response first
    tbl.push_back(mk(1, 0, 0, 0, 1, 32'h0000_0002, 0, 0, 0, 1, 1, 0)); // then inst
    tbl.push_back(mk(1, 0, 0, 0, 1, 32'h0000_00FF, 0, 0, 0, 1, 0, 0)); // stray, empty
    tbl.push_back(mk(1, 1, 0, 0, 0, 32'h0,         1, 0, 0, 0, 0, 0)); // inst stalled
    tbl.push_back(mk(1, 1, 1, 0, 0, 32'h0,         1, 0, 0, 0, 0, 0)); // lock holds inst
    tbl.push_back(mk(1, 1, 1, 0, 0, 32'h0,         1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 32'h0,         1, 1, 0, 0, 0, 0)); // inst accepted
    tbl.push_back(mk(1, 0, 1, 1, 0, 32'h0,         1, 0, 1, 1, 0, 0)); // then data
    tbl.push_back(mk(1, 1, 0, 1, 0, 32'h0,         0, 0, 0, 0, 0, 0)); // full: no req
    tbl.push_back(mk(1, 1, 0, 1, 1, 32'h1234_5678, 0, 0, 0, 0, 1, 0)); // inst data_ok
    tbl.push_back(mk(1, 1, 0, 1, 0, 32'h0,         1, 1, 0, 0, 0, 0)); // req re-enabled
    tbl.push_back(mk(1, 1, 1, 1, 1, 32'hCAFE_0003, 0, 0, 0, 1, 0, 1)); // full: pop, no push
    tbl.push_back(mk(1, 0, 0, 0, 1, 32'h0000_0004, 0, 0, 0, 1, 1, 0)); // one left
    tbl.push_back(mk(1, 0, 0, 0, 1, 32'h0000_0044, 0, 0, 0, 1, 0, 0)); // now empty
    tbl.push_back(mk(1, 1, 1, 1, 0, 32'h0,         1, 0, 1, 1, 0, 0)); // two outstanding
    tbl.push_back(mk(1, 1, 0, 1, 0, 32'h0,         1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 32'h0000_0055, 0, 0, 0, 1, 0, 0)); // reset pulse
    tbl.push_back(mk(1, 0, 0, 0, 1, 32'h0000_0066, 0, 0, 0, 1, 0, 0)); // stray discarded
    tbl.push_back(mk(1, 0, 0, 0, 1, 32'h0000_0066, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 32'h0,         1, 1, 0, 0, 0, 0)); // accept after reset
    tbl.push_back(mk(1, 0, 1, 1, 1, 32'h0000_0005, 1, 0, 1, 1, 1, 0)); // push+pop same cycle
    tbl.push_back(mk(1, 0, 0, 0, 1, 32'h0000_0006, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 32'h0000_0077, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 0, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      @(posedge clk); #1;
      v = tbl[k];
      v.idx = k;
      resetn = v.rstn; inst_req = v.ireq; data_req = v.dreq;
      mem_addr_ok = v.aok; mem_data_ok = v.dok; mem_rdata = v.rdata;
      exp_q.push_back(v);
    end

    // Random traffic: masters hold req until accepted; memory answers in order
    cyc = 0; i_pend = 1'b0; d_pend = 1'b0; i_seq = 0; d_seq = 0;
    i_cur = 32'h0; d_cur = 32'h0;
    @(posedge clk); #1;
    rand_mode = 1'b1;
    for (int c = 0; c < 700; c++) begin
      if (c != 0) begin
        @(posedge clk); #1;
      end
      cyc++;
      if (!i_pend && c < 500 && $urandom_range(0, 2) != 0) begin
        i_pend = 1'b1; i_seq++; i_cur = 32'h1000_0000 + 32'(i_seq * 4);
      end
      if (!d_pend && c < 500 && $urandom_range(0, 2) != 0) begin
        d_pend = 1'b1; d_seq++; d_cur = 32'h2000_0000 + 32'(d_seq * 4);
      end
      inst_req = i_pend; inst_addr = i_cur;
      data_req = d_pend; data_addr = d_cur;
      mem_addr_ok = ($urandom_range(0, 5) < 3);
      if (mem_q.size() != 0 && cyc >= mem_q[0].ready) begin
        mem_data_ok = 1'b1; mem_rdata = ~mem_q[0].addr;
        void'(mem_q.pop_front());
      end else begin
        mem_data_ok = 1'b0; mem_rdata = 32'h0;
      end
      @(negedge clk);
      if (inst_req && inst_addr_ok) begin
        exp_i.push_back(~inst_addr); n_iss_i++; i_pend = 1'b0;
      end
      if (data_req && data_addr_ok) begin
        exp_d.push_back(~data_addr); n_iss_d++; d_pend = 1'b0;
      end
      if (mem_req && mem_addr_ok) begin
        m.addr = mem_addr; m.ready = cyc + 1 + int'($urandom_range(0, 5));
        mem_q.push_back(m);
      end
    end
    @(posedge clk); #1;
    inst_req = 1'b0; data_req = 1'b0; mem_data_ok = 1'b0;
    @(negedge clk);

    n_cmp++;
    if (exp_i.size() != 0 || n_rcv_i != n_iss_i || n_iss_i == 0) begin
      n_err++;
      $display("FAIL rand_inst_count: received %0d left %0d expected %0d received, 0 left",
               n_rcv_i, exp_i.size(), n_iss_i);
    end
    n_cmp++;
    if (exp_d.size() != 0 || n_rcv_d != n_iss_d || n_iss_d == 0) begin
      n_err++;
      $display("FAIL rand_data_count: received %0d left %0d expected %0d received, 0 left",
               n_rcv_d, exp_d.size(), n_iss_d);
    end
    n_cmp++;
    if (exp_q.size() != 0 || mem_q.size() != 0 || i_pend || d_pend) begin
      n_err++;
      $display("FAIL drain: vectors left %0d mem left %0d pend %b%b expected all zero",
               exp_q.size(), mem_q.size(), i_pend, d_pend);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 SHALL have parameter OUTSTANDING, default 2, meaning the maximum number of accepted requests still awaiting data_ok (legal range 1..4).
REQ-002 SHALL have ports: clk  in  1  clock; resetn  in  1  reset, synchronous, active-low.
REQ-003 SHALL have inst master ports: inst_req in 1; inst_wr in 1; inst_size in 2; inst_wstrb in 4; inst_addr in 32; inst_wdata in 32; inst_addr_ok out 1; inst_data_ok out 1; inst_rdata out 32.
REQ-004 SHALL have data master ports with identical directions and widths, prefixed data_ (data_req ... data_rdata).
REQ-005 SHALL have memory slave ports: mem_req out 1; mem_wr out 1; mem_size out 2; mem_wstrb out 4; mem_addr out 32; mem_wdata out 32; mem_addr_ok in 1; mem_data_ok in 1; mem_rdata in 32.

Function
REQ-006 SHALL implement the sram-like protocol on all sides: request accepted in the cycle req & addr_ok; response delivered in the cycle data_ok; responses returned in acceptance order.
REQ-007 SHALL arbitrate with fixed priority, data over inst, when no grant is locked.
REQ-008 SHALL lock the grant while mem_req=1 and mem_addr_ok=0, so that mem_wr/size/wstrb/addr/wdata stay sourced from the same master until acceptance, even if the other master raises req.
REQ-009 SHALL release the lock in the cycle mem_req & mem_addr_ok; arbitration restarts next cycle.
REQ-010 SHALL drive mem_req = (inst_req | data_req) & ~full, where full is a registered flag (count == OUTSTANDING); no combinational path from mem_data_ok to mem_req.
REQ-011 SHALL mux mem_wr/size/wstrb/addr/wdata from the granted master; with no request the mux selects data.
REQ-012 SHALL drive inst_addr_ok = mem_addr_ok & mem_req & grant_inst and data_addr_ok = mem_addr_ok & mem_req & grant_data; never both high.
REQ-013 SHALL push the granted master ID (0=inst, 1=data) into an in-order ID FIFO of depth OUTSTANDING on each acceptance.
REQ-014 SHALL, on mem_data_ok, pop the FIFO head and raise inst_data_ok or data_data_ok for that cycle only, per head ID.
REQ-015 SHALL drive inst_rdata = data_rdata = mem_rdata unconditionally (combinational).
REQ-016 SHALL support simultaneous push and pop: count unchanged, pointers both advance, wrap modulo OUTSTANDING.
REQ-017 SHALL ignore mem_data_ok when the FIFO is empty (no data_ok to either master, count stays 0).
REQ-018 SHALL, when full, hold mem_req low; a pop in that cycle re-enables mem_req from the next cycle.
REQ-019 SHALL keep both master data_ok low in every cycle without mem_data_ok.

Reset
REQ-020 SHALL, while resetn=0 at a clk edge, clear count, rd/wr pointers, full, and grant lock.
REQ-021 SHALL hold all *_addr_ok, *_data_ok and mem_req at 0 during reset; mem_data_ok arriving for requests issued before reset is discarded.
REQ-022 SHALL accept a new request in the first cycle after resetn rises.

Structure
REQ-023 SHALL place master ID encodings (ID_INST=0, ID_DATA=1) and the OUTSTANDING default in the shared cpu header/package.
REQ-024 SHALL implement the ID FIFO as one sub-module, id_fifo (1-bit wide, parameterised depth, push/pop/full/empty/head).
REQ-025 SHALL contain no other sub-modules; total RTL 120-400 lines.

Verification
REQ-026 SHALL test: inst_req=1, data_req=1 same cycle, mem_addr_ok=1 -> data_addr_ok=1, inst_addr_ok=0, mem_addr = data_addr; inst accepted next cycle.
REQ-027 SHALL test: inst_req with mem_addr_ok=0 for 3 cycles, data_req rises cycle 2 -> mem_addr stays inst_addr until accept, then data granted.
REQ-028 SHALL test: OUTSTANDING=2, accept inst then data, no data_ok -> mem_req=0; mem_data_ok with rdata=32'h1234_5678 -> inst_data_ok=1, inst_rdata=32'h1234_5678; mem_req=1 next cycle.
REQ-029 SHALL test: full FIFO with push and pop attempted same cycle -> no push (mem_req=0), pop occurs, count=1.
REQ-030 SHALL test: two requests outstanding, resetn=0 one cycle, then stray mem_data_ok -> no master data_ok, count=0.
REQ-031 SHALL test: random inst/data traffic, random addr_ok/data_ok latency 0-5 cycles -> each master receives responses in its own issue order, none lost or duplicated.
